// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding constants and immediate-format selectors.
// Also used by the ID-stage immediate extractor.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] JALR   = 7'h67;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-in / word-out handshake bundle for the instruction encoder.
// slave = encoder side, master = producer/consumer side.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        imm_src;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport slave (
    input  in_valid, imm_src, opcode, rd,
    input  rs1, rs2, funct3, imm, out_ready,
    output in_ready, out_valid, out_instr,
    output out_addr, out_err
  );

  modport master (
    output in_valid, imm_src, opcode, rd,
    output rs1, rs2, funct3, imm, out_ready,
    input  in_ready, out_valid, out_instr,
    input  out_addr, out_err
  );
endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Combinational I/S/B/J packer with signed-range legality check.
// Inverse of the ID-stage immediate extractor.
module instr_encoder_imm_pack
  import instr_encoder_pkg::*;
(
  input  imm_src_e    src_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        legal_o
);

  logic fits12;
  logic fits13;
  logic fits21;

  // Sign-extension check: every bit above the field matches its MSB.
  assign fits12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign fits13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign fits21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  always_comb begin
    instr_o = NOP_INSTR;
    legal_o = 1'b0;
    unique case (1'b1)
      (src_i == IMM_I): begin
        instr_o = {imm_i[11:0], rs1_i, funct3_i,
                   rd_i, opcode_i};
        legal_o = fits12;
      end
      (src_i == IMM_S): begin
        instr_o = {imm_i[11:5], rs2_i, rs1_i,
                   funct3_i, imm_i[4:0], opcode_i};
        legal_o = fits12;
      end
      (src_i == IMM_B): begin
        instr_o = {imm_i[12], imm_i[10:5], rs2_i,
                   rs1_i, funct3_i, imm_i[4:1],
                   imm_i[11], opcode_i};
        legal_o = fits13 & ~imm_i[0];
      end
      (src_i == IMM_J): begin
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11],
                   imm_i[19:12], rd_i, opcode_i};
        legal_o = fits21 & ~imm_i[0];
      end
      default: begin
        instr_o = NOP_INSTR;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Registered RV32I instruction encoder with IMEM address stamping,
// sticky error flag and end-of-memory stall.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_encoder_if.slave       bus,
  output logic                 err_sticky,
  input  logic                 err_clr,
  output logic                 full,
  input  logic                 addr_clr
);

  localparam logic [ADDR_W-1:0] ADDR_ONE =
    {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_LAST =
    {ADDR_W{1'b1}};

  logic              in_ready;
  logic              accept;
  logic              emit;
  logic [31:0]       pk_instr;
  logic              pk_legal;

  logic              valid_q,  valid_d;
  logic [31:0]       instr_q,  instr_d;
  logic [ADDR_W-1:0] oaddr_q,  oaddr_d;
  logic              err_q,    err_d;
  logic [ADDR_W-1:0] cnt_q,    cnt_d;
  logic              full_q,   full_d;
  logic              sticky_q, sticky_d;

  instr_encoder_imm_pack u_pack (
    .src_i    (imm_src_e'(bus.imm_src)),
    .opcode_i (bus.opcode),
    .rd_i     (bus.rd),
    .rs1_i    (bus.rs1),
    .rs2_i    (bus.rs2),
    .funct3_i (bus.funct3),
    .imm_i    (bus.imm),
    .instr_o  (pk_instr),
    .legal_o  (pk_legal)
  );

  assign in_ready = ~full_q & (~valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  assign emit     = valid_q & bus.out_ready;

  always_comb begin
    valid_d  = valid_q;
    instr_d  = instr_q;
    oaddr_d  = oaddr_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    full_d   = full_q;
    sticky_d = sticky_q;

    if (accept) begin
      valid_d = 1'b1;
      instr_d = pk_legal ? pk_instr : NOP_INSTR;
      err_d   = ~pk_legal;
      oaddr_d = cnt_q;
      cnt_d   = cnt_q + ADDR_ONE;
      if (cnt_q == ADDR_LAST) begin
        full_d = 1'b1;
      end
    end else if (emit) begin
      valid_d = 1'b0;
    end

    // Clear wins over the increment of a coincident accept.
    if (addr_clr) begin
      cnt_d  = '0;
      full_d = 1'b0;
    end

    // A new error wins over a coincident clear.
    if (err_clr) begin
      sticky_d = 1'b0;
    end
    if (accept & ~pk_legal) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      instr_q  <= '0;
      oaddr_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      oaddr_q  <= oaddr_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_instr = instr_q;
  assign bus.out_addr  = oaddr_q;
  assign bus.out_err   = err_q;
  assign err_sticky    = sticky_q;
  assign full          = full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors plus random
// beats checked against a range/bit-field reference model.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_clr = 1'b0;
  logic addr_clr = 1'b0;
  logic err_sticky;
  logic full;

  instr_encoder_if #(.ADDR_W(AW)) bus();

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .full       (full),
    .addr_clr   (addr_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          addr;
    bit          err;
    logic [31:0] imm;
    logic [1:0]  src;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;

  int cnt_m = 0;
  bit full_m = 0;
  bit ov_m = 0;
  bit sticky_m = 0;

  logic [31:0] pend_instr;
  bit          pend_err;

  bit rmode = 0;
  bit rforce = 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic bit legal_m(input logic [1:0] src,
                                 input logic [31:0] imm);
    int v;
    v = $signed(imm);
    case (src)
      2'd0, 2'd1: return v >= -2048 && v <= 2047;
      2'd2: return v >= -4096 && v <= 4095 && (v & 1) == 0;
      default: return v >= -(1 << 20) && v < (1 << 20) && (v & 1) == 0;
    endcase
  endfunction

  function automatic logic [31:0] pack_m(
    input logic [1:0] src, input logic [6:0] op,
    input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [2:0] f3,
    input logic [31:0] imm);
    case (src)
      2'd0: return {imm[11:0], rs1, f3, rd, op};
      2'd1: return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      2'd2: return {imm[12], imm[10:5], rs2, rs1, f3,
                    imm[4:1], imm[11], op};
      default: return {imm[20], imm[10:1], imm[11],
                       imm[19:12], rd, op};
    endcase
  endfunction

  // ID-stage style extraction, used to prove the round trip.
  function automatic logic [31:0] extract(input logic [1:0] src,
                                          input logic [31:0] i);
    case (src)
      2'd0: return {{20{i[31]}}, i[31:20]};
      2'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
      2'd2: return {{19{i[31]}}, i[31], i[7], i[30:25],
                    i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20],
                       i[30:21], 1'b0};
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    bus.out_ready = rmode ? ($urandom_range(0, 3) != 0) : rforce;
  end

  // Reference model: handshake, address counter and flags.
  always @(negedge clk) begin
    bit acc;
    bit rdy;
    if (rst) begin
      cnt_m = 0;
      full_m = 0;
      ov_m = 0;
      sticky_m = 0;
      sb.delete();
    end else begin
      rdy = !full_m && (!ov_m || bus.out_ready);
      chk("in_ready", bus.in_ready, rdy);
      chk("out_valid", bus.out_valid, ov_m);
      chk("full", full, full_m);
      chk("err_sticky", err_sticky, sticky_m);
      acc = bus.in_valid && rdy;
      if (acc) sb.push_back('{pend_instr, cnt_m, pend_err,
                              bus.imm, bus.imm_src});
      ov_m = acc || (ov_m && !bus.out_ready);
      if (err_clr) sticky_m = 0;
      if (acc && pend_err) sticky_m = 1;
      if (acc) begin
        if (cnt_m == DEPTH - 1) full_m = 1;
        cnt_m = (cnt_m + 1) % DEPTH;
      end
      if (addr_clr) begin
        cnt_m = 0;
        full_m = 0;
      end
    end
  end

  // Monitor: pops on every emitted beat, checks stall stability.
  logic [31:0] h_instr;
  logic [AW-1:0] h_addr;
  logic h_err;
  bit hold = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold = 0;
    end else begin
      if (hold) begin
        chk("hold_instr", bus.out_instr, h_instr);
        chk("hold_addr", bus.out_addr, h_addr);
        chk("hold_err", bus.out_err, h_err);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("beat_expected", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("out_instr", bus.out_instr, e.instr);
          chk("out_addr", bus.out_addr, e.addr);
          chk("out_err", bus.out_err, e.err);
          if (!e.err)
            chk("reextract", extract(e.src, bus.out_instr), e.imm);
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      h_instr = bus.out_instr;
      h_addr = bus.out_addr;
      h_err = bus.out_err;
    end
  end

  task automatic send(input logic [1:0] src, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [31:0] imm, input bit use_lit,
                      input logic [31:0] lit);
    bit acc;
    int n;
    bus.imm_src = src;
    bus.opcode = op;
    bus.rd = rd;
    bus.rs1 = rs1;
    bus.rs2 = rs2;
    bus.funct3 = f3;
    bus.imm = imm;
    pend_err = !legal_m(src, imm);
    if (use_lit) pend_instr = lit;
    else if (pend_err) pend_instr = 32'h0000_0013;
    else pend_instr = pack_m(src, op, rd, rs1, rs2, f3, imm);
    bus.in_valid = 1'b1;
    acc = 0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    chk("send_accepted", acc, 1);
  endtask

  task automatic pulse_addr_clr();
    @(posedge clk); #1;
    addr_clr = 1'b1;
    @(posedge clk); #1;
    addr_clr = 1'b0;
  endtask

  task automatic pulse_err_clr();
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic send_rand();
    logic [1:0] src;
    int v;
    int k;
    src = 2'($urandom_range(0, 3));
    k = $urandom_range(0, 7);
    case (src)
      2'd0, 2'd1: v = $urandom_range(0, 4095) - 2048;
      2'd2: v = ($urandom_range(0, 4095) - 2048) * 2;
      default: v = ($urandom_range(0, (1 << 20) - 1) - (1 << 19)) * 2;
    endcase
    if (k == 6) v = v | 1;
    if (k == 7) v = int'($urandom());
    send(src, 7'($urandom()), 5'($urandom()), 5'($urandom()),
         5'($urandom()), 3'($urandom()), 32'(v), 0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.imm_src = '0;
    bus.opcode = '0;
    bus.rd = '0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    bus.funct3 = '0;
    bus.imm = '0;
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_instr", bus.out_instr, 0);
    chk("rst_out_addr", bus.out_addr, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_full", full, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(2'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF,
         1, 32'hFFF0_0093);
    send(2'd1, 7'h23, 5'd0, 5'd3, 5'd2, 3'b010, 32'd8,
         1, 32'h0021_A423);
    send(2'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd4,
         1, 32'hFE20_8EE3);
    send(2'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800,
         1, 32'h0010_00EF);
    repeat (2) @(negedge clk);
    chk("full_after_wrap", full, 1);
    chk("in_ready_when_full", bus.in_ready, 0);
    pulse_addr_clr();
    chk("full_after_clr", full, 0);

    send(2'd0, 7'h13, 5'd4, 5'd5, 5'd0, 3'd0, 32'd2048,
         1, 32'h0000_0013);
    send(2'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 32'd6, 0, 32'h0);
    send(2'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 32'd5,
         1, 32'h0000_0013);
    repeat (2) @(negedge clk);
    chk("sticky_set", err_sticky, 1);
    pulse_err_clr();
    chk("sticky_cleared", err_sticky, 0);
    err_clr = 1'b1;
    send(2'd0, 7'h13, 5'd4, 5'd5, 5'd0, 3'd0, 32'd4096,
         1, 32'h0000_0013);
    err_clr = 1'b0;
    chk("sticky_set_wins", err_sticky, 1);
    pulse_addr_clr();

    rforce = 1'b0;
    fork
      begin
        send(2'd0, 7'h03, 5'd7, 5'd8, 5'd0, 3'd2, 32'd100, 0, 32'h0);
        send(2'd1, 7'h23, 5'd0, 5'd8, 5'd9, 3'd2, -32'sd100, 0, 32'h0);
        send(2'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, -32'sd2048, 0, 32'h0);
      end
      begin
        repeat (4) @(posedge clk);
        #2 rforce = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    pulse_addr_clr();

    rmode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (full_m) pulse_addr_clr();
      if ($urandom_range(0, 15) == 0) pulse_err_clr();
      send_rand();
    end

    rmode = 1'b0;
    rforce = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    pulse_addr_clr();

    rforce = 1'b0;
    send(2'd0, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 32'd1, 0, 32'h0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_addr", bus.out_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    rforce = 1'b1;
    send(2'd2, 7'h63, 5'd0, 5'd4, 5'd6, 3'd5, -32'sd16, 0, 32'h0);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
